// File: rtl/serial_tx_param_if.sv
// rtl/serial_tx_param_if.sv - load handshake and strobed serial line of the transmitter
interface serial_tx_param_if #(
   parameter int WIDTH = 7
);
   logic [WIDTH-1:0] data_in;
   logic             load;
   logic             ready;
   logic             busy;
   logic             data_line;
   logic             strobe;
   logic             done;

   modport master (
      output data_in, load,
      input  ready, busy, data_line, strobe, done
   );

   modport slave (
      input  data_in, load,
      output ready, busy, data_line, strobe, done
   );
endinterface

// File: rtl/serial_tx_param.sv
// rtl/serial_tx_param.sv - strobed serial transmitter with bit order, parity and gap options
// The first bit leaves on the accept edge; done marks the cycle after the last bit.
module serial_tx_param #(
   parameter int WIDTH      = 7,
   parameter int MSB_FIRST  = 1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int GAP        = 0
) (
   input logic             clk,
   input logic             rst,
   serial_tx_param_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);
   localparam logic          ODD_BIT  = (PARITY_ODD != 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_PARITY,
      S_GAP
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    bit_cnt;
   logic [GW-1:0]    gap_cnt;
   logic             par_bit;
   logic             line_q;
   logic             strobe_q;
   logic             done_q;
   logic             frame_last;

   function automatic logic next_bit(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
   endfunction

   // The bit currently on the line is the final one of the frame.
   assign frame_last = ((state == S_SHIFT) && (bit_cnt == LAST_BIT) && (PARITY_EN == 0))
                       || (state == S_PARITY);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
         par_bit  <= 1'b0;
         line_q   <= 1'b0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
      end else if (frame_last) begin
         line_q   <= 1'b0;
         strobe_q <= 1'b0;
         done_q   <= 1'b1;
         bit_cnt  <= '0;
         if (GAP > 0) begin
            state   <= S_GAP;
            gap_cnt <= GAP_LOAD;
         end else begin
            state <= S_IDLE;
         end
      end else begin
         case (state)
            S_IDLE: begin
               done_q   <= 1'b0;
               line_q   <= 1'b0;
               strobe_q <= 1'b0;
               if (bus.load) begin
                  shreg    <= advance(bus.data_in);
                  line_q   <= next_bit(bus.data_in);
                  strobe_q <= 1'b1;
                  par_bit  <= (^bus.data_in) ^ ODD_BIT;
                  bit_cnt  <= CNT_ONE;
                  state    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bit_cnt == LAST_BIT) begin
                  line_q <= par_bit;
                  state  <= S_PARITY;
               end else begin
                  line_q  <= next_bit(shreg);
                  shreg   <= advance(shreg);
                  bit_cnt <= bit_cnt + CNT_ONE;
               end
            end
            S_GAP: begin
               done_q <= 1'b0;
               if (gap_cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GAP_ONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.ready     = (state == S_IDLE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.data_line = line_q;
   assign bus.strobe    = strobe_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_serial_tx_param.sv
// tb/tb_serial_tx_param.sv - bench for serial_tx_param across five parameter sets
// Instances: 0 default, 1 LSB first, 2 even parity, 3 odd parity, 4 GAP=3.
module tb_serial_tx_param;
   typedef struct {
      int         n;
      logic [7:0] bits;
   } frame_t;

   typedef struct {
      int         g;
      logic [6:0] word;
      int         n;
      logic [7:0] bits;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [6:0] data_in;
   logic [4:0] ld;
   logic [4:0] stb, dl, dn, rdy, bsy;

   int checks = 0;
   int failures = 0;

   frame_t     exp_q[5][$];
   logic [7:0] cur_bits[5];
   int         cur_n[5];

   for (genvar g = 0; g < 5; g++) begin : g_dut
      localparam int MSB = (g == 1) ? 0 : 1;
      localparam int PEN = (g == 2 || g == 3) ? 1 : 0;
      localparam int POD = (g == 3) ? 1 : 0;
      localparam int GP  = (g == 4) ? 3 : 0;
      serial_tx_param_if #(.WIDTH(7)) bus ();
      assign bus.data_in = data_in;
      assign bus.load    = ld[g];
      assign stb[g]      = bus.strobe;
      assign dl[g]       = bus.data_line;
      assign dn[g]       = bus.done;
      assign rdy[g]      = bus.ready;
      assign bsy[g]      = bus.busy;
      serial_tx_param #(
         .WIDTH(7), .MSB_FIRST(MSB), .PARITY_EN(PEN), .PARITY_ODD(POD), .GAP(GP)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .bus(bus)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic frame_t model(input int g, input logic [6:0] w);
      frame_t f;
      f.n = 7;
      f.bits = '0;
      for (int i = 0; i < 7; i++)
         f.bits = {f.bits[6:0], (g == 1) ? w[i] : w[6-i]};
      if (g == 2 || g == 3) begin
         f.n = 8;
         f.bits = {f.bits[6:0], (^w) ^ (g == 3)};
      end
      return f;
   endfunction

   // Collects strobed bits per instance and checks each frame against the scoreboard on done.
   initial begin
      frame_t f;
      for (int g = 0; g < 5; g++) begin cur_n[g] = 0; cur_bits[g] = '0; end
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int g = 0; g < 5; g++) begin cur_n[g] = 0; cur_bits[g] = '0; end
         end else begin
            for (int g = 0; g < 5; g++) begin
               if (stb[g]) begin
                  cur_bits[g] = {cur_bits[g][6:0], dl[g]};
                  cur_n[g]++;
               end else begin
                  if (dl[g]) chk($sformatf("line_low_g%0d", g), dl[g], 0);
                  if (dn[g]) begin
                     if (exp_q[g].size() == 0) begin
                        chk($sformatf("extra_frame_g%0d", g), 1, 0);
                     end else begin
                        f = exp_q[g].pop_front();
                        chk($sformatf("nbits_g%0d", g), cur_n[g], f.n);
                        chk($sformatf("bits_g%0d", g), cur_bits[g], f.bits);
                        chk($sformatf("done_ready_g%0d", g), rdy[g], (g == 4) ? 0 : 1);
                     end
                     cur_n[g] = 0;
                     cur_bits[g] = '0;
                  end else if (cur_n[g] != 0) begin
                     chk($sformatf("strobe_gap_g%0d", g), cur_n[g], 0);
                     cur_n[g] = 0;
                     cur_bits[g] = '0;
                  end
               end
            end
         end
      end
   end

   task automatic send(input int g, input logic [6:0] w, input frame_t f);
      int t = 0;
      @(negedge clk);
      while (!rdy[g] && t < 50) begin @(negedge clk); t++; end
      if (!rdy[g]) chk("ready_timeout", 0, 1);
      data_in = w;
      ld[g] = 1'b1;
      exp_q[g].push_back(f);
      @(negedge clk);
      ld[g] = 1'b0;
   endtask

   task automatic wait_idle(input int g);
      int t = 0;
      while ((exp_q[g].size() != 0 || !rdy[g]) && t < 100) begin @(negedge clk); t++; end
      chk($sformatf("idle_g%0d", g), (exp_q[g].size() == 0 && rdy[g]), 1);
   endtask

   vec_t vecs[8];

   initial begin
      int low;
      int cnt;
      logic [6:0] w;
      frame_t tmp;

      vecs[0] = '{0, 7'b1011001, 7, 8'b01011001};
      vecs[1] = '{1, 7'b1011001, 7, 8'b01001101};
      vecs[2] = '{2, 7'b1011001, 8, 8'b10110010};
      vecs[3] = '{3, 7'b1011001, 8, 8'b10110011};
      vecs[4] = '{2, 7'b0000001, 8, 8'b00000011};
      vecs[5] = '{0, 7'h55,      7, 8'b01010101};
      vecs[6] = '{1, 7'h01,      7, 8'b01000000};
      vecs[7] = '{4, 7'h7F,      7, 8'b01111111};

      rst = 1'b1;
      ld = '0;
      data_in = '0;
      #12;
      chk("rst_ready", rdy, 5'h1F);
      chk("rst_busy", bsy, 0);
      chk("rst_strobe", stb, 0);
      chk("rst_line", dl, 0);
      chk("rst_done", dn, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         tmp.n = vecs[i].n;
         tmp.bits = vecs[i].bits;
         send(vecs[i].g, vecs[i].word, tmp);
         wait_idle(vecs[i].g);
      end

      for (int g = 0; g < 5; g++) begin
         for (int k = 0; k < 3; k++) begin
            w = 7'($urandom);
            send(g, w, model(g, w));
            wait_idle(g);
         end
      end

      // Back-to-back frames with load held high on the GAP=3 instance.
      @(negedge clk);
      data_in = 7'h55;
      ld[4] = 1'b1;
      exp_q[4].push_back(model(4, 7'h55));
      @(negedge clk);
      chk("hold_first_strobe", stb[4], 1);
      data_in = 7'h2A;
      exp_q[4].push_back(model(4, 7'h2A));
      cnt = 0;
      while (!dn[4] && cnt < 20) begin @(negedge clk); cnt++; end
      chk("hold_done_seen", dn[4], 1);
      low = 0;
      while (!stb[4] && low < 20) begin low++; @(negedge clk); end
      chk("hold_gap_len", low, 4);
      ld[4] = 1'b0;
      wait_idle(4);

      // Load during an active frame is dropped.
      send(0, 7'b1100110, model(0, 7'b1100110));
      @(negedge clk);
      @(negedge clk);
      chk("busy_mid_frame", rdy[0], 0);
      data_in = 7'h0F;
      ld[0] = 1'b1;
      @(negedge clk);
      ld[0] = 1'b0;
      wait_idle(0);
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (stb[0]) cnt++;
      end
      chk("no_extra_strobes", cnt, 0);

      // Asynchronous reset during bit 4 aborts the frame immediately.
      send(0, 7'b0110101, model(0, 7'b0110101));
      repeat (3) @(posedge clk);
      #2;
      chk("pre_abort_strobe", stb[0], 1);
      rst = 1'b1;
      #1;
      chk("abort_strobe", stb[0], 0);
      chk("abort_line", dl[0], 0);
      chk("abort_busy", bsy[0], 0);
      chk("abort_done", dn[0], 0);
      chk("abort_ready", rdy[0], 1);
      exp_q[0].delete();
      @(negedge clk);
      #1;
      rst = 1'b0;
      send(0, 7'b0110101, '{7, 8'b00110101});
      wait_idle(0);
      repeat (5) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
